// File: rtl/offnariscv_pkg.sv
// rtl/offnariscv_pkg.sv - shared pipeline constants for the inter-stage fifos
package offnariscv_pkg;

  localparam int IFID_FIFO_DEPTH = 2;
  localparam int IDRF_FIFO_DEPTH = 2;
  localparam int EXWB_FIFO_DEPTH = 2;

endpackage

// File: rtl/pipe_fifo.sv
// rtl/pipe_fifo.sv - first-word-fall-through pipeline fifo with flush and almost-full
module pipe_fifo
  import offnariscv_pkg::*;
#(
  parameter type tdata_t   = logic [31:0],
  parameter int  DEPTH     = 2,
  parameter int  AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  tdata_t                     s_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output tdata_t                     m_tdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  tdata_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign s_tready = (count_q != CW'(DEPTH));
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign afull    = (count_q >= CW'(AFULL_LVL));

  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so wrap is free.
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_q[wr_ptr_q] <= s_tdata;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && count_q == CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop && count_q == '0));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (m_tvalid && !m_tready && !flush) |=> $stable(m_tdata));
`endif

endmodule

// File: tb/tb_pipe_fifo.sv
// tb/tb_pipe_fifo.sv - randomized and directed bench for pipe_fifo against a queue model
module tb_pipe_fifo;

  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [2:0]  count;
  logic        afull;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [$];

  pipe_fifo #(
    .tdata_t   (logic [31:0]),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .count    (count),
    .afull    (afull)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = model.size();
    check("count", 32'(count), 32'(n));
    check("m_tvalid", 32'(m_tvalid), 32'(n != 0));
    check("s_tready", 32'(s_tready), 32'(n != DEPTH));
    check("afull", 32'(afull), 32'(n >= AFULL));
    if (n != 0) check("m_tdata", m_tdata, model[0]);
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model and compare.
  task automatic step(input logic sv, input logic [31:0] d, input logic mr,
                      input logic fl, input logic rs);
    bit push, pop;
    s_tvalid = sv;
    s_tdata  = d;
    m_tready = mr;
    flush    = fl;
    rst      = rs;
    push = sv && (model.size() < DEPTH);
    pop  = mr && (model.size() != 0);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      model.delete();
    end else begin
      if (pop)  void'(model.pop_front());
      if (push) model.push_back(d);
    end
    check_all();
  endtask

  initial begin
    logic [31:0] vals [4];
    vals = '{32'h11, 32'h22, 32'h33, 32'h44};

    s_tvalid = 0; s_tdata = 0; m_tready = 0; flush = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Fill with consumer stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(1, vals[i], 0, 0, 0);
    step(1, 32'h66, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

    // Streaming through pointer wrap.
    for (int i = 0; i < 16; i++) step(1, 32'(i), 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 32'h70 + 32'(i), 0, 0, 0);
    step(1, 32'h55, 1, 0, 0);
    step(1, 32'h55, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

    // Flush with a push in the same cycle.
    for (int i = 0; i < 3; i++) step(1, 32'h80 + 32'(i), 0, 0, 0);
    step(1, 32'h99, 0, 1, 0);
    step(0, 0, 1, 0, 0);

    // Reset mid-operation, then single-cycle latency on a fresh push.
    for (int i = 0; i < 2; i++) step(1, 32'h90 + 32'(i), 0, 0, 0);
    step(0, 0, 1, 0, 1);
    step(1, 32'hAB, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    for (int c = 0; c < 10000; c++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_fifo.md
PIPE_FIFO -- requirements
Module: pipe_fifo

Interface
REQ-001 Parameter tdata_t, type, logic [31:0], payload type (any packed pipeline struct, e.g. ifid_tdata_t).
REQ-002 Parameter DEPTH, int, 2, entry count; power of two, >= 2.
REQ-003 Parameter AFULL_LVL, int, DEPTH-1, almost-full threshold; 1..DEPTH.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 flush  in  1  squash all held entries (mispredict/trap redirect).
REQ-007 s_tvalid  in  1  upstream payload valid.
REQ-008 s_tready  out  1  fifo can accept.
REQ-009 s_tdata  in  $bits(tdata_t)  upstream payload.
REQ-010 m_tvalid  out  1  head entry valid.
REQ-011 m_tready  in  1  downstream accepts head.
REQ-012 m_tdata  out  $bits(tdata_t)  head entry payload.
REQ-013 count  out  $clog2(DEPTH+1)  entries held.
REQ-014 afull  out  1  count >= AFULL_LVL.

Function
REQ-015 Push = s_tvalid & s_tready; pop = m_tvalid & m_tready; both evaluated same cycle.
REQ-016 s_tready = (count != DEPTH); no combinational dependence on m_tready or s_tvalid.
REQ-017 m_tvalid = (count != 0); m_tdata = storage[rd_ptr], first-word-fall-through from storage register.
REQ-018 Latency: payload pushed in cycle N visible on m_tdata/m_tvalid in cycle N+1 when fifo was empty; no same-cycle bypass.
REQ-019 Full throughput: one push and one pop per cycle sustained; simultaneous push+pop leaves count unchanged.
REQ-020 Full: push blocked (s_tready=0); pop in same cycle frees entry, s_tready rises next cycle.
REQ-021 Empty: pop impossible (m_tvalid=0); push alone sets count=1 next cycle.
REQ-022 Pointers wr_ptr, rd_ptr are $clog2(DEPTH) bits, wrap modulo DEPTH with no extra logic; count tracks occupancy separately.
REQ-023 count next = count + push - pop; never exceeds DEPTH nor underflows.
REQ-024 m_tvalid held with m_tdata stable until pop (AXI-Stream rule); s_tdata captured only on push.
REQ-025 flush: next cycle count=0, rd_ptr=wr_ptr=0; push and pop in flush cycle ignored for state update.
REQ-026 flush with s_tvalid=1 same cycle: that payload discarded, s_tready still reflects pre-flush state.
REQ-027 afull registered-free: combinational compare of count against AFULL_LVL.

Reset
REQ-028 rst: count=0, wr_ptr=0, rd_ptr=0 next edge; outputs m_tvalid=0, s_tready=1, afull=0 (AFULL_LVL>=1), count=0.
REQ-029 Storage array not reset; m_tdata undefined while m_tvalid=0.
REQ-030 rst mid-operation discards all entries identically to flush; rst has priority over flush, push, pop.

Structure
REQ-031 Per-boundary depth constants (IFID_FIFO_DEPTH, IDRF_FIFO_DEPTH, EXWB_FIFO_DEPTH) live in offnariscv_pkg; no new types in package.
REQ-032 No sub-module; storage is a register array of tdata_t inside pipe_fifo.
REQ-033 Assertions (non-SYNTHESIS): no push when count==DEPTH, no pop when count==0, m_tdata stable while m_tvalid & !m_tready.

Verification (DEPTH=4, AFULL_LVL=3, tdata_t=logic[31:0])
REQ-034 Push 0x11,0x22,0x33,0x44 with m_tready=0 -> count 1..4, afull=1 at count 3, s_tready=0 after 4th; then m_tready=1 -> pops 0x11..0x44 in order.
REQ-035 Continuous push 0x00..0x0F with m_tready=1 -> one output per cycle, count steady 1, order preserved across pointer wrap.
REQ-036 Full fifo, s_tvalid=1 with 0x55 and pop same cycle -> 0x55 not accepted that cycle, accepted next cycle, count returns to 4.
REQ-037 3 entries held, flush=1 with s_tvalid=1 0x99 -> next cycle count=0, m_tvalid=0, 0x99 never emitted.
REQ-038 rst asserted with 2 entries held and m_tready=1 -> next cycle count=0, m_tvalid=0, s_tready=1; subsequent push 0xAB emerges after 1 cycle.
REQ-039 Random valid/ready toggling 10k cycles vs scoreboard -> no loss, duplication, reorder; count matches model every cycle.
